// File: rtl/cpu_mem_bridge_pkg.sv
// Shared constants, FSM state type and helpers for the CPU-to-BRAM bridge.
// The write-counter address constant matters only when CPU_MEM_BRIDGE_WR_CNT_EN is defined.
package cpu_mem_bridge_pkg;

  localparam logic [1:0]  BRAM_SELECT_0 = 2'd0;
  localparam logic [1:0]  BRAM_SELECT_1 = 2'd1;
  localparam logic [1:0]  BRAM_SELECT_2 = 2'd2;
  localparam logic [1:0]  BRAM_SELECT_3 = 2'd3;

  localparam logic [15:0] ADDR_WR_CNT   = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD
  } bridge_state_e;

  function automatic logic is_wr_cnt_addr(input logic [1:0] sel, input logic [13:0] addr);
    return (sel == ADDR_WR_CNT[15:14]) && (addr == ADDR_WR_CNT[13:0]);
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// Memory-side bus between the bridge (master) and the BRAM block (slave).
interface memory_bus_if;

  logic        BUS_CLK;
  logic [1:0]  BRAM_SELECT;
  logic [13:0] BRAM_ADDR;
  logic        EN;
  logic        WE;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;

  modport master (
    output BUS_CLK, BRAM_SELECT, BRAM_ADDR, EN, WE, DATA_IN,
    input  DATA_OUT
  );

  modport slave (
    input  BUS_CLK, BRAM_SELECT, BRAM_ADDR, EN, WE, DATA_IN,
    output DATA_OUT
  );

endinterface

// File: rtl/cpu_mem_bridge_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous strobe, with single-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/cpu_mem_bridge.sv
// Converts the MCU asynchronous memory strobes into single-cycle BRAM accesses.
// Define CPU_MEM_BRIDGE_WR_CNT_EN to map a write-pulse counter at address 16'hFFFF.
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CPU_CS_N,
  input  logic         CPU_WE_N,
  input  logic         CPU_RD_N,
  input  logic [15:0]  CPU_ADDR,
  input  logic [15:0]  CPU_DATA_IN,
  output logic [15:0]  CPU_DATA_OUT,
  output logic         CPU_DATA_OE,
  memory_bus_if.master MEM_BUS
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic w_cs_n_lvl, w_rd_n_lvl, w_we_rise, w_rd_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_we (
    .i_clk(CLK), .i_rst(RST), .i_async(CPU_WE_N),
    .o_level(), .o_rise(w_we_rise), .o_fall()
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rd (
    .i_clk(CLK), .i_rst(RST), .i_async(CPU_RD_N),
    .o_level(w_rd_n_lvl), .o_rise(), .o_fall(w_rd_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(CLK), .i_rst(RST), .i_async(CPU_CS_N),
    .o_level(w_cs_n_lvl), .o_rise(), .o_fall()
  );

  // Address/data delayed by the same depth as the strobes so they line up.
  logic [SYNC_STAGES-1:0][15:0] r_addr_pipe, r_data_pipe;
  logic [15:0] w_addr_s, w_data_s;

  // NOTE: this pipeline is deliberately not reset; its contents are only
  // consumed when qualified by a synchronized strobe edge.
  always_ff @(posedge CLK) begin
    r_addr_pipe <= {r_addr_pipe[SYNC_STAGES-2:0], CPU_ADDR};
    r_data_pipe <= {r_data_pipe[SYNC_STAGES-2:0], CPU_DATA_IN};
  end

  assign w_addr_s = r_addr_pipe[SYNC_STAGES-1];
  assign w_data_s = r_data_pipe[SYNC_STAGES-1];

  bridge_state_e     r_state, w_state_nxt;
  logic [1:0]        r_sel;
  logic [13:0]       r_addr;
  logic [15:0]       r_wdata, r_rdata, w_rd_value;
  logic              r_oe, r_abandon;
  logic [WAIT_W-1:0] r_wait;
  logic              w_start_wr, w_start_rd, w_en, w_we, w_abort;

  assign w_abort = w_rd_n_lvl | w_cs_n_lvl;

  // NOTE: combinational logic uses blocking assignments with every output
  // defaulted first, so no path through the case can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start_wr  = 1'b0;
    w_start_rd  = 1'b0;
    w_en        = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_we_rise && !w_cs_n_lvl) begin
          w_start_wr  = 1'b1;
          w_state_nxt = WR;
        end else if (w_rd_fall && !w_cs_n_lvl) begin
          w_start_rd  = 1'b1;
          w_state_nxt = RD_ISSUE;
        end
      end
      WR: begin
        w_en        = 1'b1;
        w_we        = 1'b1;
        w_state_nxt = IDLE;
      end
      RD_ISSUE: begin
        w_en        = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (r_wait == '0) w_state_nxt = (r_abandon || w_abort) ? IDLE : RD_HOLD;
      end
      RD_HOLD: begin
        if (w_abort) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef CPU_MEM_BRIDGE_WR_CNT_EN
  logic [15:0] r_wr_cnt;

  always_ff @(posedge CLK) begin
    if (RST)                r_wr_cnt <= 16'd0;
    else if (r_state == WR) r_wr_cnt <= r_wr_cnt + 16'd1;
  end

  assign w_rd_value = is_wr_cnt_addr(r_sel, r_addr) ? r_wr_cnt : MEM_BUS.DATA_OUT;
`else
  assign w_rd_value = MEM_BUS.DATA_OUT;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_oe      <= 1'b0;
      r_abandon <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_wr) begin
        r_sel   <= w_addr_s[15:14];
        r_addr  <= w_addr_s[13:0];
        r_wdata <= w_data_s;
      end else if (w_start_rd) begin
        r_sel  <= w_addr_s[15:14];
        r_addr <= w_addr_s[13:0];
      end
      if (r_state == RD_ISSUE)                    r_wait <= WAIT_W'(READ_LATENCY - 1);
      else if (r_state == RD_WAIT && r_wait != '0) r_wait <= r_wait - WAIT_W'(1);
      // A strobe released mid-read lets the access finish but suppresses OE.
      if (r_state == IDLE) r_abandon <= 1'b0;
      else if ((r_state == RD_ISSUE || r_state == RD_WAIT) && w_abort) r_abandon <= 1'b1;
      if (r_state == RD_WAIT && w_state_nxt == RD_HOLD) r_rdata <= w_rd_value;
      r_oe <= (w_state_nxt == RD_HOLD);
    end
  end

  assign MEM_BUS.BUS_CLK     = CLK;
  assign MEM_BUS.EN          = w_en;
  assign MEM_BUS.WE          = w_we;
  assign MEM_BUS.BRAM_SELECT = r_sel;
  assign MEM_BUS.BRAM_ADDR   = r_addr;
  assign MEM_BUS.DATA_IN     = r_wdata;
  assign CPU_DATA_OUT        = r_rdata;
  assign CPU_DATA_OE         = r_oe;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: drives MCU strobes on the falling clock edge,
// models a 2-cycle-latency BRAM, and checks bus pulses, latencies and read data.
module tb_cpu_mem_bridge;
  import cpu_mem_bridge_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CPU_CS_N = 1'b1;
  logic        CPU_WE_N = 1'b1;
  logic        CPU_RD_N = 1'b1;
  logic [15:0] CPU_ADDR = '0;
  logic [15:0] CPU_DATA_IN = '0;
  logic [15:0] CPU_DATA_OUT;
  logic        CPU_DATA_OE;

  memory_bus_if u_bus ();

  cpu_mem_bridge #(.SYNC_STAGES(2), .READ_LATENCY(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CPU_CS_N    (CPU_CS_N),
    .CPU_WE_N    (CPU_WE_N),
    .CPU_RD_N    (CPU_RD_N),
    .CPU_ADDR    (CPU_ADDR),
    .CPU_DATA_IN (CPU_DATA_IN),
    .CPU_DATA_OUT(CPU_DATA_OUT),
    .CPU_DATA_OE (CPU_DATA_OE),
    .MEM_BUS     (u_bus.master)
  );

  always #5 CLK = ~CLK;

  // BRAM model: data appears exactly two clocks after the EN read pulse, garbage otherwise.
  logic [15:0] mem [0:65535];
  logic [15:0] r_s1;

  always @(posedge u_bus.BUS_CLK) begin
    if (u_bus.EN && u_bus.WE) mem[{u_bus.BRAM_SELECT, u_bus.BRAM_ADDR}] <= u_bus.DATA_IN;
    r_s1 <= (u_bus.EN && !u_bus.WE) ? mem[{u_bus.BRAM_SELECT, u_bus.BRAM_ADDR}] : 16'hDEAD;
    u_bus.DATA_OUT <= r_s1;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          cyc, en_pulses, en_first, oe_cycles, oe_first;
  int          consec = 0;
  logic        prev_en = 1'b0;
  logic        en_we;
  logic [1:0]  en_sel;
  logic [13:0] en_addr;
  logic [15:0] en_data;

  task automatic clear_mon();
    cyc = 0; en_pulses = 0; en_first = -1; oe_cycles = 0; oe_first = -1;
  endtask

  // Advance to the next falling edge and record what the bus showed in the cycle just completed.
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (u_bus.EN) begin
      en_pulses++;
      if (prev_en) consec++;
      if (en_first < 0) begin
        en_first = cyc;
        en_we    = u_bus.WE;
        en_sel   = u_bus.BRAM_SELECT;
        en_addr  = u_bus.BRAM_ADDR;
        en_data  = u_bus.DATA_IN;
      end
    end
    prev_en = u_bus.EN;
    if (CPU_DATA_OE) begin
      oe_cycles++;
      if (oe_first < 0) oe_first = cyc;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"},   u_bus.EN, 0);
    check({tag, "_we"},   u_bus.WE, 0);
    check({tag, "_sel"},  u_bus.BRAM_SELECT, 0);
    check({tag, "_addr"}, u_bus.BRAM_ADDR, 0);
    check({tag, "_din"},  u_bus.DATA_IN, 0);
    check({tag, "_dout"}, CPU_DATA_OUT, 0);
    check({tag, "_oe"},   CPU_DATA_OE, 0);
  endtask

  // EN is expected SYNC_STAGES+1 = 3 cycles after the WE_N rise.
  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input string tag);
    CPU_CS_N = 1'b0; CPU_ADDR = a; CPU_DATA_IN = d; CPU_WE_N = 1'b0;
    repeat (4) step();
    CPU_WE_N = 1'b1;
    clear_mon();
    repeat (6) step();
    check({tag, "_lat"},   en_first, 3);
    check({tag, "_cnt"},   en_pulses, 1);
    check({tag, "_we"},    en_we, 1);
    check({tag, "_sel"},   en_sel, a[15:14]);
    check({tag, "_addr"},  en_addr, a[13:0]);
    check({tag, "_data"},  en_data, d);
    CPU_CS_N = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [15:0] exp_cnt_rd;
    mem[16'h4100] = 16'h1234;
    mem[16'h8055] = 16'h7777;
    mem[16'hFFFF] = 16'hBEEF;
    clear_mon();

    repeat (3) step();
    check_reset_vals("rst0");
    RST = 1'b0;
    repeat (3) step();

    cpu_write(16'h0012, 16'hA5A5, "wr1");

    // Read 4100: EN at 3, OE with data at SYNC_STAGES+2+READ_LATENCY = 6, held for 20 cycles.
    CPU_CS_N = 1'b0; CPU_ADDR = 16'h4100;
    step();
    CPU_RD_N = 1'b0;
    clear_mon();
    repeat (20) step();
    check("rd_en_lat",  en_first, 3);
    check("rd_en_cnt",  en_pulses, 1);
    check("rd_en_we",   en_we, 0);
    check("rd_sel",     en_sel, BRAM_SELECT_1);
    check("rd_addr",    en_addr, 14'h0100);
    check("rd_oe_lat",  oe_first, 6);
    check("rd_oe_len",  oe_cycles, 15);
    check("rd_data",    CPU_DATA_OUT, 16'h1234);
    // OE drops one cycle after synchronized RD_N goes high (3 pad cycles here).
    CPU_RD_N = 1'b1;
    repeat (2) step();
    check("rd_oe_held", CPU_DATA_OE, 1);
    step();
    check("rd_oe_drop", CPU_DATA_OE, 0);
    CPU_CS_N = 1'b1;
    repeat (3) step();

    // Abandoned read: RD_N released as soon as EN is seen.
    CPU_CS_N = 1'b0; CPU_ADDR = 16'h8055;
    step();
    CPU_RD_N = 1'b0;
    clear_mon();
    for (int i = 0; i < 15; i++) begin
      step();
      if (u_bus.EN) CPU_RD_N = 1'b1;
    end
    CPU_RD_N = 1'b1;
    check("ab_en_cnt", en_pulses, 1);
    check("ab_en_lat", en_first, 3);
    check("ab_oe",     oe_cycles, 0);
    CPU_CS_N = 1'b1;
    repeat (2) step();
    cpu_write(16'h0034, 16'h5A5A, "wr2");

    // WE_N rise and RD_N fall in the same cycle: write wins, read dropped.
    CPU_CS_N = 1'b0; CPU_ADDR = 16'h0077; CPU_DATA_IN = 16'h1111; CPU_WE_N = 1'b0;
    repeat (4) step();
    CPU_WE_N = 1'b1; CPU_RD_N = 1'b0;
    clear_mon();
    repeat (10) step();
    check("both_en_cnt", en_pulses, 1);
    check("both_we",     en_we, 1);
    check("both_addr",   en_addr, 14'h0077);
    check("both_oe",     oe_cycles, 0);
    CPU_RD_N = 1'b1; CPU_CS_N = 1'b1;
    repeat (3) step();

    // Reset in the cycle after a WE_N rise aborts the write.
    CPU_CS_N = 1'b0; CPU_ADDR = 16'h0099; CPU_DATA_IN = 16'h2222; CPU_WE_N = 1'b0;
    repeat (4) step();
    CPU_WE_N = 1'b1;
    clear_mon();
    step();
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    repeat (6) step();
    check("rstmid_en_cnt", en_pulses, 0);
    check_reset_vals("rstmid");
    CPU_CS_N = 1'b1;
    repeat (2) step();

    // Five writes, then a read of FFFF: counter value with the feature, memory otherwise.
    for (int i = 0; i < 5; i++) cpu_write(16'h0200 + 16'(i), 16'h0100 + 16'(i), "cw");
`ifdef CPU_MEM_BRIDGE_WR_CNT_EN
    exp_cnt_rd = 16'h0005;
`else
    exp_cnt_rd = 16'hBEEF;
`endif
    CPU_CS_N = 1'b0; CPU_ADDR = 16'hFFFF;
    step();
    CPU_RD_N = 1'b0;
    clear_mon();
    repeat (8) step();
    check("cnt_en_cnt", en_pulses, 1);
    check("cnt_sel",    en_sel, BRAM_SELECT_3);
    check("cnt_oe_lat", oe_first, 6);
    check("cnt_data",   CPU_DATA_OUT, exp_cnt_rd);
    CPU_RD_N = 1'b1; CPU_CS_N = 1'b1;
    repeat (4) step();

    check("en_consec", consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
